avalon_edge_pio: RTL and testbench

Parametrised Avalon-MM input PIO with per-bit edge capture and interrupt. It takes WIDTH asynchronous input lines, for example vsync/refresh strobes, buttons and status lines from the HDMI path. Each line passes through a multi-stage synchronizer and a programmable per-bit glitch filter. Rising and/or falling edges are latched per bit, and a level interrupt goes to the Nios II. It supersedes the single-bit, rising-edge-only input PIOs in the Qsys system.

---
 rtl/avalon_edge_pio.sv | 138 +++++++++++++
 tb/tb_avalon_edge_pio.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_edge_pio.sv
// ============================================================================
//  Module   : avalon_edge_pio
//  Purpose  : Avalon-MM input PIO with synchronizer, glitch filter, per-bit
//             rising/falling edge capture and a level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_edge_pio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [2:0] C_ADDR_DATA     = 3'd0;
  localparam logic [2:0] C_ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] C_ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] C_ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] C_ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] C_ADDR_FILT_LEN = 3'd5;
  localparam logic [2:0] C_ADDR_RAW      = 3'd6;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_chain;
  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_filt;
  logic [WIDTH-1:0]  w_upd;
  logic [WIDTH-1:0]  w_edge_set;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_irq_mask;
  logic [WIDTH-1:0]  r_edge_cap;
  logic [WIDTH-1:0]  r_fall_en;
  logic [FILT_W-1:0] r_filt_len;
  logic [31:0]       w_rd_mux;
  logic              w_wr;
  logic              w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;

  // Stage 0 samples the pin; the last stage is the synchronized value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_chain <= '0;
    end else begin
      r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync = r_sync_chain[SYNC_STAGES-1];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_filt
      logic [FILT_W-1:0] r_cnt;
      logic              r_filt_bit;

      // The >= compare lets a shortened FILT_LEN fire at once instead of wrapping.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt      <= '0;
          r_filt_bit <= 1'b0;
        end else if (w_sync[i] == r_filt_bit) begin
          r_cnt <= '0;
        end else if (r_cnt >= r_filt_len) begin
          r_filt_bit <= w_sync[i];
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + FILT_W'(1);
        end
      end

      assign w_filt[i] = r_filt_bit;
      assign w_upd[i]  = (w_sync[i] != r_filt_bit) && (r_cnt >= r_filt_len);
    end
  endgenerate

  // On an update the new filtered value equals w_sync, so it gives the edge direction.
  assign w_edge_set = w_upd & ((w_sync & r_rise_en) | (~w_sync & r_fall_en));
  assign w_clr      = (w_wr && address == C_ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_en  <= '1;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_fall_en  <= '0;
      r_filt_len <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge_set;
      if (w_wr) begin
        case (address)
          C_ADDR_RISE_EN:  r_rise_en  <= writedata[WIDTH-1:0];
          C_ADDR_IRQ_MASK: r_irq_mask <= writedata[WIDTH-1:0];
          C_ADDR_FALL_EN:  r_fall_en  <= writedata[WIDTH-1:0];
          C_ADDR_FILT_LEN: r_filt_len <= writedata[FILT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      C_ADDR_DATA:     w_rd_mux[WIDTH-1:0]  = w_filt;
      C_ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0]  = r_rise_en;
      C_ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0]  = r_irq_mask;
      C_ADDR_EDGE_CAP: w_rd_mux[WIDTH-1:0]  = r_edge_cap;
      C_ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0]  = r_fall_en;
      C_ADDR_FILT_LEN: w_rd_mux[FILT_W-1:0] = r_filt_len;
      C_ADDR_RAW:      w_rd_mux[WIDTH-1:0]  = w_sync;
      default:         w_rd_mux             = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_avalon_edge_pio.sv
// ============================================================================
//  Module   : tb_avalon_edge_pio
//  Purpose  : Scoreboard bench for avalon_edge_pio against a window-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avalon_edge_pio;

  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int FW    = 8;
  localparam int HLEN  = 300;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [WIDTH-1:0]  in_port = '0;
  logic [31:0]       readdata;
  logic              irq;

  always #5 clk = ~clk;

  avalon_edge_pio #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bit is accepted once the last FILT_LEN+1 synchronized
  // samples all disagree with the currently accepted value.
  logic [WIDTH-1:0] m_filt, m_rise, m_mask, m_cap, m_fall;
  int unsigned      m_flen;
  logic [WIDTH-1:0] hist[$];
  logic [31:0]      sb_q[$];
  int               sb_a[$];

  function automatic logic [WIDTH-1:0] sync_seen(input int age);
    return hist[hist.size() - 1 - SS - age];
  endfunction

  function automatic logic [WIDTH-1:0] next_filt();
    logic [WIDTH-1:0] nf;
    logic [WIDTH-1:0] s;
    logic             flip;
    nf = m_filt;
    for (int b = 0; b < WIDTH; b++) begin
      flip = 1'b1;
      for (int k = 0; k <= int'(m_flen); k++) begin
        s = sync_seen(k);
        if (s[b] == m_filt[b]) flip = 1'b0;
      end
      if (flip) nf[b] = ~m_filt[b];
    end
    return nf;
  endfunction

  function automatic logic [WIDTH-1:0] edge_set(input logic [WIDTH-1:0] nf);
    return (nf ^ m_filt) & ((nf & m_rise) | (~nf & m_fall));
  endfunction

  function automatic logic [WIDTH-1:0] clr_mask();
    if (chipselect && !write_n && address == 3'd3) return writedata[WIDTH-1:0];
    return '0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_filt);
      3'd1:    return 32'(m_rise);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_cap);
      3'd4:    return 32'(m_fall);
      3'd5:    return 32'(m_flen);
      3'd6:    return 32'(sync_seen(0));
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_filt <= '0;
      m_rise <= '1;
      m_mask <= '0;
      m_cap  <= '0;
      m_fall <= '0;
      m_flen <= 0;
      hist.delete();
      for (int k = 0; k < HLEN; k++) hist.push_back('0);
    end else begin
      hist.push_back(in_port);
      if (hist.size() > HLEN) void'(hist.pop_front());
      if (chipselect && write_n) begin
        sb_q.push_back(exp_read(address));
        sb_a.push_back(int'(address));
      end
      m_cap  <= (m_cap & ~clr_mask()) | edge_set(next_filt());
      m_filt <= next_filt();
      if (chipselect && !write_n) begin
        case (address)
          3'd1: m_rise <= writedata[WIDTH-1:0];
          3'd2: m_mask <= writedata[WIDTH-1:0];
          3'd4: m_fall <= writedata[WIDTH-1:0];
          3'd5: m_flen <= int'(writedata[FW-1:0]);
          default: ;
        endcase
      end
    end
  end

  // Monitor: readdata is valid the cycle after a sampled read; irq every cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      chk($sformatf("rd_addr%0d", sb_a.pop_front()), readdata, sb_q.pop_front());
    end
    if (reset_n) chk("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int op;
    logic [2:0]  ra;
    logic [31:0] rd;

    idle(3);
    reset_n = 1'b1;
    idle(2);
    for (int a = 0; a < 8; a++) bus_rd(3'(a));

    // Single-bit rise with no filtering, then clear.
    bus_wr(3'd2, 32'h01);
    in_port[0] = 1'b1;
    idle(4);
    bus_rd(3'd3);
    bus_wr(3'd3, 32'h01);
    idle(2);
    bus_rd(3'd3);

    // Glitch filter: 4-cycle pulse rejected, 5-cycle pulse accepted.
    bus_wr(3'd5, 32'd4);
    in_port[1] = 1'b1; idle(4); in_port[1] = 1'b0;
    idle(10); bus_rd(3'd0); bus_rd(3'd3);
    in_port[1] = 1'b1; idle(5); in_port[1] = 1'b0;
    bus_rd(3'd0); idle(3); bus_rd(3'd0); bus_rd(3'd3);
    idle(10);

    // Falling-only, then both edges on bit 2.
    bus_wr(3'd5, 32'd0);
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd1, 32'h00);
    bus_wr(3'd4, 32'h04);
    in_port[2] = 1'b1; idle(5); bus_rd(3'd3);
    in_port[2] = 1'b0; idle(5); bus_rd(3'd3);
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd1, 32'h04);
    in_port[2] = 1'b1; idle(5); bus_rd(3'd3);
    bus_wr(3'd3, 32'hFF);
    in_port[2] = 1'b0; idle(5); bus_rd(3'd3);

    // Clear coinciding with a new bit-3 capture: the edge wins.
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd4, 32'h00);
    bus_wr(3'd2, 32'h08);
    in_port[3] = 1'b1;
    idle(2);
    bus_wr(3'd3, 32'h08);
    bus_rd(3'd3);
    idle(2);

    // Lowering FILT_LEN under a running count fires on the next cycle.
    bus_wr(3'd5, 32'd200);
    in_port[4] = 1'b1;
    idle(150);
    bus_rd(3'd0);
    bus_wr(3'd5, 32'd10);
    bus_rd(3'd0);
    bus_rd(3'd0);
    bus_rd(3'd3);

    // Asynchronous reset in the middle of a long count.
    bus_wr(3'd5, 32'd200);
    bus_wr(3'd2, 32'hFF);
    in_port[5] = 1'b1;
    idle(50);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    idle(3);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) bus_rd(3'(a));
    bus_wr(3'd2, 32'hFF);
    idle(3);
    bus_rd(3'd0);
    bus_rd(3'd3);

    // Randomized traffic.
    bus_wr(3'd5, 32'd2);
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, WIDTH - 1);
        in_port[idx] = ~in_port[idx];
      end
      op = $urandom_range(0, 9);
      ra = 3'($urandom_range(0, 7));
      rd = $urandom;
      if (ra == 3'd5) rd = $urandom_range(0, 5);
      if (op < 2)      bus_wr(ra, rd);
      else if (op < 5) bus_rd(ra);
      else             idle(1);
    end

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
